// File: rtl/nanci_edge_tx.sv
`default_nettype none
// ============================================================================
// Module      : nanci_edge_tx
// Description : Mesh-edge transmitter. Stands in for a missing neighbour of a
//               boundary PE: the host pushes {addr,data} words into a small
//               valid/ready FIFO. Each word is presented on o_PE for
//               HOLD_CYCLES unstalled cycles, then the next one follows with
//               no gap. When nothing is queued the port drives zero, which the
//               PE reads as "no neighbour".
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active high
//               i_valid    - host word valid
//               i_addr     - host word address field (MSBs of the word)
//               i_data     - host word data field (LSBs of the word)
//               o_ready    - FIFO can accept a word (not full)
//               i_stall    - freezes the hold counter and blocks pops
//               o_PE       - registered word to the PE, {addr,data}; 0 idle
//               o_PE_valid - o_PE carries a real word
//               o_count    - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module nanci_edge_tx #(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 3,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic [ADDR_WIDTH-1:0]            i_addr,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_ready,
    input  logic                             i_stall,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
    output logic                             o_PE_valid,
    output logic [$clog2(DEPTH):0]           o_count
);

    localparam int c_WORD_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    // Counter only ever holds HOLD_CYCLES-1 down to 0.
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0]  c_FULL_COUNT = c_CNT_W'(DEPTH);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST  = c_HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [0:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_WORD_W-1:0] r_pe;
    logic                r_pe_valid;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_clear;
    logic [0:0]          w_state_next;
    logic [c_HOLD_W-1:0] w_hold_next;

    // Full/empty come from registered occupancy only, so o_ready never
    // depends on i_valid and a pop on the same edge cannot free a slot.
    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = i_valid && !w_full;

    // ------------------------------------------------------------------
    // FSM: next-state, pop and hold-counter decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty && !i_stall) begin
                    w_pop        = 1'b1;
                    w_hold_next  = c_HOLD_LAST;
                    w_state_next = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                // A stall freezes everything: word, counter and FIFO head.
                if (!i_stall) begin
                    if (r_hold_cnt != '0) begin
                        w_hold_next = r_hold_cnt - c_HOLD_W'(1);
                    end else if (!w_empty) begin
                        // Back-to-back: next word replaces the current one
                        // on the same edge, so the PE never sees a zero gap.
                        w_pop       = 1'b1;
                        w_hold_next = c_HOLD_LAST;
                    end else begin
                        w_clear      = 1'b1;
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry contents need no reset: a slot is only read after it is written,
    // and reset rewinds both pointers so stale words are never reachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_addr, i_data};
        end
    end

    // ------------------------------------------------------------------
    // Output register: the only driver of o_PE, so no input reaches the PE
    // combinationally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pe       <= '0;
            r_pe_valid <= 1'b0;
        end else if (w_pop) begin
            r_pe       <= r_mem[r_rd_ptr];
            r_pe_valid <= 1'b1;
        end else if (w_clear) begin
            r_pe       <= '0;
            r_pe_valid <= 1'b0;
        end
    end

    assign o_ready    = !w_full;
    assign o_PE       = r_pe;
    assign o_PE_valid = r_pe_valid;
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_nanci_edge_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_nanci_edge_tx
// Description : Self-checking bench for nanci_edge_tx. A reference model
//               built on a plain queue predicts the visible state after every
//               clock edge and pushes it into a scoreboard; a monitor pops one
//               entry per cycle and compares it with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nanci_edge_tx;

    localparam int c_AW    = 3;
    localparam int c_DW    = 3;
    localparam int c_DEPTH = 4;
    localparam int c_HOLD  = 2;
    localparam int c_W     = c_AW + c_DW;
    localparam int c_CW    = $clog2(c_DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic [c_AW-1:0]   i_addr;
    logic [c_DW-1:0]   i_data;
    logic              o_ready;
    logic              i_stall;
    logic [c_W-1:0]    o_PE;
    logic              o_PE_valid;
    logic [c_CW-1:0]   o_count;

    nanci_edge_tx #(
        .ADDR_WIDTH  (c_AW),
        .DATA_WIDTH  (c_DW),
        .DEPTH       (c_DEPTH),
        .HOLD_CYCLES (c_HOLD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_stall    (i_stall),
        .o_PE       (o_PE),
        .o_PE_valid (o_PE_valid),
        .o_count    (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            pe_valid;
        logic [c_W-1:0]  pe;
        logic [c_CW-1:0] count;
        logic            ready;
    } exp_t;

    exp_t exp_q [$];
    int   checks;
    int   errors;
    bit   done;

    // ------------------------------------------------------------------
    // Reference model. A word stays up for c_HOLD unstalled edges; when its
    // time is up (or nothing is shown) the oldest queued word takes over.
    // Words pushed on this edge cannot be shown until the next one.
    // ------------------------------------------------------------------
    int unsigned    m_fifo [$];
    logic           m_valid;
    logic [c_W-1:0] m_word;
    int             m_left;

    initial begin
        exp_t e;
        bit   acc;
        m_valid = 1'b0;
        m_word  = '0;
        m_left  = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_fifo.delete();
                m_valid = 1'b0;
                m_word  = '0;
                m_left  = 0;
            end else begin
                acc = i_valid && (m_fifo.size() < c_DEPTH);
                if (!i_stall) begin
                    if (m_valid) m_left = m_left - 1;
                    if (!m_valid || m_left == 0) begin
                        if (m_fifo.size() > 0) begin
                            m_word  = c_W'(m_fifo.pop_front());
                            m_valid = 1'b1;
                            m_left  = c_HOLD;
                        end else begin
                            m_valid = 1'b0;
                            m_word  = '0;
                        end
                    end
                end
                if (acc) m_fifo.push_back(int'({i_addr, i_data}));
            end
            e.pe_valid = m_valid;
            e.pe       = m_valid ? m_word : '0;
            e.count    = c_CW'(m_fifo.size());
            e.ready    = (m_fifo.size() < c_DEPTH);
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one scoreboard entry per edge, compared mid-cycle.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("o_PE_valid", 32'(o_PE_valid), 32'(e.pe_valid));
                check("o_PE",       32'(o_PE),       32'(e.pe));
                check("o_count",    32'(o_count),    32'(e.count));
                check("o_ready",    32'(o_ready),    32'(e.ready));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit v, input logic [c_W-1:0] w, input bit s, input bit r);
        @(posedge clk);
        #1;
        i_valid = v;
        {i_addr, i_data} = w;
        i_stall = s;
        rst     = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [c_W-1:0] w;
        checks  = 0;
        errors  = 0;
        done    = 1'b0;
        rst     = 1'b1;
        i_valid = 1'b1;
        i_addr  = 3'b101;
        i_data  = 3'b010;
        i_stall = 1'b0;

        // Reset held two edges with a word offered: nothing may be queued.
        drive(1'b1, 6'b111111, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        idle(2);

        // Single word, then return to zero.
        drive(1'b1, 6'b011000, 1'b0, 1'b0);
        idle(5);

        // Four words back-to-back, each held c_HOLD cycles with no gap.
        drive(1'b1, 6'b001000, 1'b0, 1'b0);
        drive(1'b1, 6'b010000, 1'b0, 1'b0);
        drive(1'b1, 6'b011000, 1'b0, 1'b0);
        drive(1'b1, 6'b100000, 1'b0, 1'b0);
        idle(12);

        // Fill under stall: fifth word refused, then drain.
        for (int i = 1; i <= 6; i++) drive(1'b1, c_W'(i * 9), 1'b1, 1'b0);
        idle(14);

        // Stall for two cycles in the middle of a hold.
        drive(1'b1, 6'b110101, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle(6);

        // Reset with three words queued and one on the port.
        for (int i = 0; i < 4; i++) drive(1'b1, c_W'(6'b100001 + i), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 6'b111000, 1'b0, 1'b1);
        drive(1'b1, 6'b000111, 1'b0, 1'b0);
        drive(1'b1, 6'b101101, 1'b0, 1'b0);
        idle(10);

        // Randomized traffic with occasional stalls and rare resets.
        for (int i = 0; i < 400; i++) begin
            w = c_W'($urandom);
            drive(($urandom % 10) < 6, w, ($urandom % 10) < 2, ($urandom % 150) == 0);
        end
        idle(20);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
